// File: rtl/pillar_pkg.sv
// Shared encodings for the operand issue slice: instruction classes, FSM states, shift funct3 codes.
package pillar_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned REG_AW    = 5;
  localparam int unsigned ITYPE_W   = 5;

  // One-hot instruction class encodings from the decoder
  localparam logic [ITYPE_W-1:0] RTYPE = 5'b00001;
  localparam logic [ITYPE_W-1:0] ITYPE = 5'b00010;
  localparam logic [ITYPE_W-1:0] STYPE = 5'b00100;
  localparam logic [ITYPE_W-1:0] LTYPE = 5'b01000;
  localparam logic [ITYPE_W-1:0] UTYPE = 5'b10000;

  // Immediate shifts use a 5-bit zero-extended shamt instead of imm[11:0]
  localparam logic [2:0] F3_SLLI = 3'b001;
  localparam logic [2:0] F3_SRXI = 3'b101;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RDREQ  = 3'd1,
    LATCH  = 3'd2,
    STROBE = 3'd3,
    DONE   = 3'd4
  } issue_state_t;

endpackage

// File: rtl/imm_gen.sv
// Combinational immediate extraction and sign-extension per instruction class.
module imm_gen
  import pillar_pkg::*;
(
  input  logic [XLEN-1:0]    ir,
  input  logic [ITYPE_W-1:0] itype,
  output logic [XLEN-1:0]    imm
);

  logic       unused_ir;
  logic [2:0] funct3;

  assign unused_ir = ^ir[6:0];
  assign funct3    = ir[14:12];

  always_comb begin
    imm = '0;
    case (itype)
      ITYPE: begin
        if (funct3 == F3_SLLI || funct3 == F3_SRXI)
          imm = {27'b0, ir[24:20]};
        else
          imm = {{20{ir[31]}}, ir[31:20]};
      end
      LTYPE:   imm = {{20{ir[31]}}, ir[31:20]};
      STYPE:   imm = {{20{ir[31]}}, ir[31:25], ir[11:7]};
      UTYPE:   imm = {ir[31:12], 12'b0};
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/operand_issue.sv
// Fetches register operands, builds ALU operand buses and pulses the ALU load strobes.
// Optional writeback bypass enabled with macro FORWARD_EN.
module operand_issue
  import pillar_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start_i,
  input  logic [XLEN-1:0]      ir_i,
  input  logic [ITYPE_W-1:0]   itype_i,
  output logic [REG_AW-1:0]    rf_raddr_a_o,
  output logic [REG_AW-1:0]    rf_raddr_b_o,
  input  logic [XLEN-1:0]      rf_rdata_a_i,
  input  logic [XLEN-1:0]      rf_rdata_b_i,
`ifdef FORWARD_EN
  input  logic                 wb_we_i,
  input  logic [REG_AW-1:0]    wb_rd_i,
  input  logic [XLEN-1:0]      wb_data_i,
`endif
  output logic [XLEN-1:0]      readd_a_o,
  output logic [XLEN-1:0]      readd_b_o,
  output logic [XLEN-1:0]      readd_pass_o,
  output logic                 readin_a_o,
  output logic                 readin_b_o,
  output logic                 readin_pass_o,
  output logic                 busy_o,
  output logic                 done_o
);

  issue_state_t    state;
  logic [REG_AW-1:0] rs1;
  logic [REG_AW-1:0] rs2;
  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;

  assign rs1          = ir_i[19:15];
  assign rs2          = ir_i[24:20];
  assign rf_raddr_a_o = rs1;
  assign rf_raddr_b_o = rs2;

  imm_gen u_imm_gen (
    .ir    (ir_i),
    .itype (itype_i),
    .imm   (imm)
  );

  // Register operands: x0 reads as zero, otherwise RF data or the writeback bypass
  always_comb begin
    op_a = rf_rdata_a_i;
    op_b = rf_rdata_b_i;
`ifdef FORWARD_EN
    if (wb_we_i && wb_rd_i == rs1) op_a = wb_data_i;
    if (wb_we_i && wb_rd_i == rs2) op_b = wb_data_i;
`endif
    if (rs1 == '0) op_a = '0;
    if (rs2 == '0) op_b = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      readd_a_o     <= '0;
      readd_b_o     <= '0;
      readd_pass_o  <= '0;
      readin_a_o    <= 1'b0;
      readin_b_o    <= 1'b0;
      readin_pass_o <= 1'b0;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
    end else begin
      readin_a_o    <= 1'b0;
      readin_b_o    <= 1'b0;
      readin_pass_o <= 1'b0;
      done_o        <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            state  <= RDREQ;
            busy_o <= 1'b1;
          end
        end
        RDREQ: state <= LATCH;
        LATCH: begin
          state <= STROBE;
          // Buses are loaded a full cycle ahead of the strobe edge
          case (itype_i)
            RTYPE: begin
              readd_a_o <= op_a;
              readd_b_o <= op_b;
            end
            ITYPE, LTYPE: begin
              readd_a_o <= op_a;
              readd_b_o <= imm;
            end
            STYPE: begin
              readd_a_o    <= op_a;
              readd_b_o    <= imm;
              readd_pass_o <= op_b;
            end
            UTYPE: begin
              readd_a_o <= imm;
              readd_b_o <= '0;
            end
            default: ;
          endcase
        end
        STROBE: begin
          state <= DONE;
          case (itype_i)
            RTYPE, ITYPE, LTYPE, UTYPE: begin
              readin_a_o <= 1'b1;
              readin_b_o <= 1'b1;
            end
            STYPE: begin
              readin_a_o    <= 1'b1;
              readin_b_o    <= 1'b1;
              readin_pass_o <= 1'b1;
            end
            default: ;
          endcase
        end
        DONE: begin
          state  <= IDLE;
          busy_o <= 1'b0;
          done_o <= 1'b1;
        end
        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule
